// File: rtl/cpu_test_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_test_sequencer
// Brief    : Test harness controller for the CPU cores. It streams instruction
//            and data memory images in and holds the CPU in reset while forcing
//            the start PC. It then runs the CPU under a cycle budget and
//            reports pass, fail or timeout from a signature store.
// Revision : 1.0 - initial release
// ============================================================================
module cpu_test_sequencer #(
    parameter int DATA_W  = 32,
    parameter int IMEM_AW = 6,
    parameter int DMEM_AW = 6,
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 600,
    parameter int RST_CYC = 2,
    localparam int LD_AW  = (IMEM_AW > DMEM_AW) ? IMEM_AW : DMEM_AW
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] start_pc,
    input  logic [DATA_W-1:0] sig_addr,
    input  logic [DATA_W-1:0] sig_expect,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic              ld_sel,
    input  logic [LD_AW-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [LD_AW-1:0]  mem_waddr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_rst,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_value,
    input  logic              mon_we,
    input  logic [DATA_W-1:0] mon_addr,
    input  logic [DATA_W-1:0] mon_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              timeout,
    output logic [CNT_W-1:0]  cycles
);

    localparam int               HC_W      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [HC_W-1:0]  HOLD_LAST = HC_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
    // Address masks make out-of-range load addresses wrap within each memory.
    localparam logic [LD_AW-1:0] IMEM_MASK = LD_AW'((1 << IMEM_AW) - 1);
    localparam logic [LD_AW-1:0] DMEM_MASK = LD_AW'((1 << DMEM_AW) - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_HOLD = 3'd2,
        S_RUN  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;
    logic [CNT_W-1:0]  cycles_q, cycles_d;
    logic              pass_q, pass_d;
    logic              timeout_q, timeout_d;
    logic              pc_load_d;

    logic              imem_we_q, dmem_we_q, pc_load_q;
    logic              cpu_rst_q, busy_q, done_q;
    logic [LD_AW-1:0]  mem_waddr_q;
    logic [DATA_W-1:0] mem_wdata_q, pc_value_q;

    logic              w_xfer;
    logic              w_sig_hit;
    logic              w_hold_last;
    logic [CNT_W-1:0]  w_cycles_inc;

    assign w_xfer       = ld_valid && (state_q == S_LOAD);
    assign w_sig_hit    = mon_we && (mon_addr == sig_addr);
    assign w_hold_last  = (hold_cnt_q == HOLD_LAST);
    assign w_cycles_inc = (cycles_q == CNT_MAX) ? cycles_q : cycles_q + CNT_W'(1);

    // Next-state and result bookkeeping; hold_cnt defaults to zero so each HOLD entry starts fresh.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = '0;
        cycles_d   = cycles_q;
        pass_d     = pass_q;
        timeout_d  = timeout_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    cycles_d  = '0;
                    pass_d    = 1'b0;
                    timeout_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (w_xfer && ld_last) begin
                    state_d = S_HOLD;
                end
            end
            S_HOLD: begin
                if (w_hold_last) begin
                    state_d = S_RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HC_W'(1);
                end
            end
            S_RUN: begin
                cycles_d = w_cycles_inc;
                // A signature store takes priority over a coincident timeout.
                if (w_sig_hit) begin
                    state_d   = S_DONE;
                    pass_d    = (mon_data == sig_expect);
                    timeout_d = 1'b0;
                end else if (w_cycles_inc >= CNT_LIMIT) begin
                    state_d   = S_DONE;
                    pass_d    = 1'b0;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        pc_load_d = (state_d == S_HOLD) && (hold_cnt_d == HOLD_LAST);
    end

    // State, counters and result flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            hold_cnt_q <= '0;
            cycles_q   <= '0;
            pass_q     <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            hold_cnt_q <= hold_cnt_d;
            cycles_q   <= cycles_d;
            pass_q     <= pass_d;
            timeout_q  <= timeout_d;
        end
    end

    // Registered outputs, decoded from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            imem_we_q   <= 1'b0;
            dmem_we_q   <= 1'b0;
            mem_waddr_q <= '0;
            mem_wdata_q <= '0;
            cpu_rst_q   <= 1'b1;
            pc_load_q   <= 1'b0;
            pc_value_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            imem_we_q <= w_xfer && !ld_sel;
            dmem_we_q <= w_xfer && ld_sel;
            if (w_xfer) begin
                mem_waddr_q <= ld_addr & (ld_sel ? DMEM_MASK : IMEM_MASK);
                mem_wdata_q <= ld_data;
            end
            cpu_rst_q <= (state_d != S_RUN);
            pc_load_q <= pc_load_d;
            if (pc_load_d) begin
                pc_value_q <= start_pc;
            end
            busy_q <= (state_d == S_LOAD) || (state_d == S_HOLD) || (state_d == S_RUN);
            done_q <= (state_d == S_DONE);
        end
    end

    assign ld_ready  = (state_q == S_LOAD);
    assign imem_we   = imem_we_q;
    assign dmem_we   = dmem_we_q;
    assign mem_waddr = mem_waddr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_rst   = cpu_rst_q;
    assign pc_load   = pc_load_q;
    assign pc_value  = pc_value_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign timeout   = timeout_q;
    assign cycles    = cycles_q;

endmodule
`default_nettype wire

// File: tb/tb_cpu_test_sequencer.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_cpu_test_sequencer
// Brief    : Self-checking bench for cpu_test_sequencer: table-driven image
//            loads plus directed run/timeout/reset sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_test_sequencer;

    localparam int DATA_W  = 32;
    localparam int IMEM_AW = 6;
    localparam int DMEM_AW = 7;
    localparam int LD_AW   = 7;
    localparam int CNT_W   = 16;

    logic              clk = 1'b0;
    logic              rst, start, ld_valid, ld_sel, ld_last, mon_we;
    logic [DATA_W-1:0] start_pc, sig_addr, sig_expect, ld_data, mon_addr, mon_data;
    logic [LD_AW-1:0]  ld_addr;
    logic              ld_ready, imem_we, dmem_we, cpu_rst, pc_load;
    logic              busy, done, pass, timeout;
    logic [LD_AW-1:0]  mem_waddr;
    logic [DATA_W-1:0] mem_wdata, pc_value;
    logic [CNT_W-1:0]  cycles;

    int n_pass  = 0;
    int n_total = 0;

    cpu_test_sequencer #(
        .DATA_W (DATA_W),
        .IMEM_AW(IMEM_AW),
        .DMEM_AW(DMEM_AW),
        .CNT_W  (CNT_W),
        .TIMEOUT(600),
        .RST_CYC(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .start_pc  (start_pc),
        .sig_addr  (sig_addr),
        .sig_expect(sig_expect),
        .ld_valid  (ld_valid),
        .ld_ready  (ld_ready),
        .ld_sel    (ld_sel),
        .ld_addr   (ld_addr),
        .ld_data   (ld_data),
        .ld_last   (ld_last),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_waddr (mem_waddr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .pc_load   (pc_load),
        .pc_value  (pc_value),
        .mon_we    (mon_we),
        .mon_addr  (mon_addr),
        .mon_data  (mon_data),
        .busy      (busy),
        .done      (done),
        .pass      (pass),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              v;
        logic              sel;
        logic [LD_AW-1:0]  addr;
        logic [DATA_W-1:0] data;
        logic              last;
        logic              e_iwe;
        logic              e_dwe;
        logic [LD_AW-1:0]  e_waddr;
        logic              e_rdy;
    } vec_t;

    vec_t vt [0:14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_ready", ld_ready, 1);
        check("start_busy", busy, 1);
        check("start_cycles_clr", cycles, 0);
    endtask

    // Apply table rows [first..last] as load beats, then check the HOLD window.
    task automatic load_image(input int first, input int last, input logic [31:0] exp_pc);
        for (int i = first; i <= last; i++) begin
            ld_valid = vt[i].v;
            ld_sel   = vt[i].sel;
            ld_addr  = vt[i].addr;
            ld_data  = vt[i].data;
            ld_last  = vt[i].last;
            step();
            check($sformatf("imem_we[%0d]", i), imem_we, vt[i].e_iwe);
            check($sformatf("dmem_we[%0d]", i), dmem_we, vt[i].e_dwe);
            check($sformatf("ld_ready[%0d]", i), ld_ready, vt[i].e_rdy);
            if (vt[i].e_iwe || vt[i].e_dwe) begin
                check($sformatf("waddr[%0d]", i), mem_waddr, vt[i].e_waddr);
                check($sformatf("wdata[%0d]", i), mem_wdata, vt[i].data);
            end
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("hold1_cpu_rst", cpu_rst, 1);
        check("hold1_pc_load", pc_load, 0);
        step();
        check("hold2_cpu_rst", cpu_rst, 1);
        check("hold2_pc_load", pc_load, 1);
        check("hold2_pc_value", pc_value, exp_pc);
        check("hold2_no_write", imem_we | dmem_we, 0);
        step();
        check("run1_cpu_rst", cpu_rst, 0);
        check("run1_pc_load", pc_load, 0);
        check("run1_busy", busy, 1);
    endtask

    // Step through RUN; drive the signature store on run cycle store_cyc and
    // optionally stores to a non-signature address on every other cycle.
    task automatic run_until(input int store_cyc, input logic [31:0] sdata,
                             input bit distract, input int budget, output int done_k);
        done_k = 0;
        for (int k = 1; k <= budget; k++) begin
            mon_we   = 1'b0;
            mon_addr = 32'h0;
            mon_data = 32'h0;
            if (k == store_cyc) begin
                mon_we   = 1'b1;
                mon_addr = 32'h8;
                mon_data = sdata;
            end else if (distract) begin
                mon_we   = 1'b1;
                mon_addr = 32'h4;
                mon_data = sig_expect;
            end
            step();
            if (done) begin
                done_k = k;
                break;
            end
        end
        mon_we = 1'b0;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int dk;
        // Image A: 4 imem beats, a bubble, 2 dmem beats.
        vt[0]  = '{1'b1, 1'b0, 7'h00, 32'h8C010000, 1'b0, 1'b1, 1'b0, 7'h00, 1'b1};
        vt[1]  = '{1'b1, 1'b0, 7'h01, 32'h8C020004, 1'b0, 1'b1, 1'b0, 7'h01, 1'b1};
        vt[2]  = '{1'b0, 1'b1, 7'h33, 32'hFFFFFFFF, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1};
        vt[3]  = '{1'b1, 1'b0, 7'h02, 32'h00221820, 1'b0, 1'b1, 1'b0, 7'h02, 1'b1};
        vt[4]  = '{1'b1, 1'b0, 7'h03, 32'hAC030008, 1'b0, 1'b1, 1'b0, 7'h03, 1'b1};
        vt[5]  = '{1'b1, 1'b1, 7'h00, 32'h00000005, 1'b0, 1'b0, 1'b1, 7'h00, 1'b1};
        vt[6]  = '{1'b1, 1'b1, 7'h01, 32'h00000007, 1'b1, 1'b0, 1'b1, 7'h01, 1'b0};
        // Image B: valid toggles every other cycle; address wrap on imem.
        vt[7]  = '{1'b1, 1'b0, 7'h45, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 7'h05, 1'b1};
        vt[8]  = '{1'b0, 1'b0, 7'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1};
        vt[9]  = '{1'b1, 1'b1, 7'h45, 32'h12345678, 1'b0, 1'b0, 1'b1, 7'h45, 1'b1};
        vt[10] = '{1'b0, 1'b1, 7'h11, 32'h0BADF00D, 1'b1, 1'b0, 1'b0, 7'h00, 1'b1};
        vt[11] = '{1'b1, 1'b1, 7'h02, 32'h00000003, 1'b0, 1'b0, 1'b1, 7'h02, 1'b1};
        vt[12] = '{1'b0, 1'b0, 7'h00, 32'h00000000, 1'b0, 1'b0, 1'b0, 7'h00, 1'b1};
        vt[13] = '{1'b1, 1'b0, 7'h7E, 32'h0000ABCD, 1'b1, 1'b1, 1'b0, 7'h3E, 1'b0};
        // Image C: single imem beat.
        vt[14] = '{1'b1, 1'b0, 7'h10, 32'h00000013, 1'b1, 1'b1, 1'b0, 7'h10, 1'b0};

        rst = 1'b1; start = 1'b0; ld_valid = 1'b0; ld_sel = 1'b0; ld_last = 1'b0;
        ld_addr = '0; ld_data = '0; mon_we = 1'b0; mon_addr = '0; mon_data = '0;
        start_pc = 32'h0; sig_addr = 32'h8; sig_expect = 32'h0000000C;
        step();
        step();
        rst = 1'b0;
        check("rst_cpu_rst", cpu_rst, 1);
        check("rst_ld_ready", ld_ready, 0);
        check("rst_we", {imem_we, dmem_we, pc_load}, 0);
        check("rst_waddr", mem_waddr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_pc_value", pc_value, 0);
        check("rst_flags", {busy, done, pass, timeout}, 0);
        check("rst_cycles", cycles, 0);
        step();
        check("idle_stays", busy, 0);

        // Passing run: signature on run cycle 4.
        do_start();
        load_image(0, 6, 32'h0);
        run_until(4, 32'h0000000C, 1'b0, 50, dk);
        check("t1_done_cycle", dk, 4);
        check("t1_flags", {done, pass, timeout, busy, cpu_rst}, 5'b11001);
        check("t1_cycles", cycles, 4);
        step();
        check("t1_hold_done", done, 1);
        check("t1_hold_cycles", cycles, 4);

        // Failing run from DONE: wrong signature data, stray stores ignored.
        start_pc = 32'h00000040;
        do_start();
        check("t2_pass_clr", pass, 0);
        load_image(7, 13, 32'h00000040);
        run_until(4, 32'h0000000D, 1'b1, 50, dk);
        check("t2_done_cycle", dk, 4);
        check("t2_flags", {done, pass, timeout}, 3'b100);
        check("t2_cycles", cycles, 4);

        // Timeout: only non-signature stores.
        do_start();
        load_image(14, 14, 32'h00000040);
        run_until(0, 32'h0, 1'b1, 700, dk);
        check("t3_done_cycle", dk, 600);
        check("t3_flags", {done, pass, timeout}, 3'b101);
        check("t3_cycles", cycles, 600);

        // Signature exactly on the timeout cycle: signature wins.
        do_start();
        check("t4_timeout_clr", timeout, 0);
        load_image(14, 14, 32'h00000040);
        run_until(600, 32'h0000000C, 1'b1, 700, dk);
        check("t4_done_cycle", dk, 600);
        check("t4_flags", {done, pass, timeout}, 3'b110);
        check("t4_cycles", cycles, 600);

        // Reset mid-run, then a fresh test.
        do_start();
        load_image(14, 14, 32'h00000040);
        run_until(0, 32'h0, 1'b0, 10, dk);
        check("t5_not_done", dk, 0);
        check("t5_cycles10", cycles, 10);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("t5_rst_cpu_rst", cpu_rst, 1);
        check("t5_rst_cycles", cycles, 0);
        check("t5_rst_flags", {busy, done, ld_ready}, 0);
        do_start();
        load_image(14, 14, 32'h00000040);
        run_until(2, 32'h0000000C, 1'b0, 50, dk);
        check("t5_done_cycle", dk, 2);
        check("t5_flags", {done, pass, timeout}, 3'b110);
        check("t5_cycles", cycles, 2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
